// File: rtl/soc_addr_decode_slice_if.sv
// rtl/soc_addr_decode_slice_if.sv - request, forward and local-error channels of the decode slice
interface soc_addr_decode_slice_if #(
    parameter int IdWidth  = 4,
    parameter int CntWidth = 16
);
    logic                req_valid_i;
    logic                req_ready_o;
    logic [63:0]         req_addr_i;
    logic                req_write_i;
    logic [7:0]          req_len_i;
    logic [IdWidth-1:0]  req_id_i;
    logic                mst_valid_o;
    logic                mst_ready_i;
    logic [63:0]         mst_addr_o;
    logic                mst_write_o;
    logic [7:0]          mst_len_o;
    logic [IdWidth-1:0]  mst_id_o;
    logic [3:0]          mst_sel_o;
    logic                err_valid_o;
    logic                err_ready_i;
    logic                err_write_o;
    logic [IdWidth-1:0]  err_id_o;
    logic                err_last_o;
    logic [1:0]          err_resp_o;
    logic [CntWidth-1:0] dec_err_cnt_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_write_i, req_len_i, req_id_i,
        input  mst_ready_i, err_ready_i,
        output req_ready_o,
        output mst_valid_o, mst_addr_o, mst_write_o, mst_len_o, mst_id_o, mst_sel_o,
        output err_valid_o, err_write_o, err_id_o, err_last_o, err_resp_o,
        output dec_err_cnt_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_write_i, req_len_i, req_id_i,
        output mst_ready_i, err_ready_i,
        input  req_ready_o,
        input  mst_valid_o, mst_addr_o, mst_write_o, mst_len_o, mst_id_o, mst_sel_o,
        input  err_valid_o, err_write_o, err_id_o, err_last_o, err_resp_o,
        input  dec_err_cnt_o
    );
endinterface

// File: rtl/soc_addr_decode_slice.sv
// rtl/soc_addr_decode_slice.sv - registered SoC address decode with local DECERR responder
module soc_addr_decode_slice #(
    parameter int          IdWidth    = 4,
    parameter logic [63:0] DRAMLength = 64'h4000_0000,
    parameter int          CntWidth   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    soc_addr_decode_slice_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_FWD, S_ERR_R, S_ERR_B} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [63:0]         r_addr;
    logic                r_write;
    logic [7:0]          r_len;
    logic [IdWidth-1:0]  r_id;
    logic [3:0]          r_sel;
    logic [7:0]          r_beat;
    logic [CntWidth-1:0] r_cnt;

    logic                w_hit;
    logic [3:0]          w_sel;
    logic                w_req_ready;
    logic                w_accept;
    logic                w_mst_valid;
    logic                w_err_valid;
    logic                w_err_write;
    logic                w_err_last;
    logic                w_beat_inc;

    function automatic logic in_win(input logic [63:0] a, input logic [63:0] base,
                                    input logic [63:0] len);
        return (a >= base) && ((a - base) < len);
    endfunction

    always_comb begin
        w_hit = 1'b1;
        w_sel = 4'd0;
        if      (in_win(bus.req_addr_i, 64'h0000_0000, 64'h0000_1000)) w_sel = 4'd10;
        else if (in_win(bus.req_addr_i, 64'h0001_0000, 64'h0001_0000)) w_sel = 4'd9;
        else if (in_win(bus.req_addr_i, 64'h0200_0000, 64'h000C_0000)) w_sel = 4'd8;
        else if (in_win(bus.req_addr_i, 64'h0C00_0000, 64'h03FF_FFFF)) w_sel = 4'd7;
        else if (in_win(bus.req_addr_i, 64'h1000_0000, 64'h0000_1000)) w_sel = 4'd6;
        else if (in_win(bus.req_addr_i, 64'h1800_0000, 64'h0000_1000)) w_sel = 4'd5;
        else if (in_win(bus.req_addr_i, 64'h2000_0000, 64'h0080_0000)) w_sel = 4'd4;
        else if (in_win(bus.req_addr_i, 64'h3000_0000, 64'h0001_0000)) w_sel = 4'd3;
        else if (in_win(bus.req_addr_i, 64'h4000_0000, 64'h0000_1000)) w_sel = 4'd2;
        else if (in_win(bus.req_addr_i, 64'h4001_0000, 64'h0000_1000)) w_sel = 4'd1;
        else if (in_win(bus.req_addr_i, 64'h8000_0000, DRAMLength))    w_sel = 4'd0;
        else w_hit = 1'b0;
    end

    // Forward-state ready follows the crossbar so a new request can replace the one leaving.
    assign w_req_ready = (r_state == S_IDLE) || ((r_state == S_FWD) && bus.mst_ready_i);
    assign w_accept    = bus.req_valid_i && w_req_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_mst_valid = 1'b0;
        w_err_valid = 1'b0;
        w_err_write = 1'b0;
        w_err_last  = 1'b0;
        w_beat_inc  = 1'b0;
        case (r_state)
            S_IDLE: ;
            S_FWD: begin
                w_mst_valid = 1'b1;
                if (bus.mst_ready_i) w_state_nxt = S_IDLE;
            end
            S_ERR_B: begin
                w_err_valid = 1'b1;
                w_err_write = 1'b1;
                w_err_last  = 1'b1;
                if (bus.err_ready_i) w_state_nxt = S_IDLE;
            end
            S_ERR_R: begin
                w_err_valid = 1'b1;
                w_err_last  = (r_beat == r_len);
                if (bus.err_ready_i) begin
                    if (w_err_last) w_state_nxt = S_IDLE;
                    else            w_beat_inc  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_accept) begin
            if (w_hit)                w_state_nxt = S_FWD;
            else if (bus.req_write_i) w_state_nxt = S_ERR_B;
            else                      w_state_nxt = S_ERR_R;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_len   <= '0;
            r_id    <= '0;
            r_sel   <= '0;
            r_beat  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_id   <= bus.req_id_i;
                r_len  <= bus.req_len_i;
                r_beat <= '0;
                if (w_hit) begin
                    r_addr  <= bus.req_addr_i;
                    r_write <= bus.req_write_i;
                    r_sel   <= w_sel;
                end else if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_beat_inc) begin
                r_beat <= r_beat + 8'd1;
            end
        end
    end

    assign bus.req_ready_o   = w_req_ready;
    assign bus.mst_valid_o   = w_mst_valid;
    assign bus.mst_addr_o    = r_addr;
    assign bus.mst_write_o   = r_write;
    assign bus.mst_len_o     = r_len;
    assign bus.mst_id_o      = r_id;
    assign bus.mst_sel_o     = r_sel;
    assign bus.err_valid_o   = w_err_valid;
    assign bus.err_write_o   = w_err_write;
    assign bus.err_id_o      = r_id;
    assign bus.err_last_o    = w_err_last;
    assign bus.err_resp_o    = 2'b11;
    assign bus.dec_err_cnt_o = r_cnt;
endmodule

// File: tb/tb_soc_addr_decode_slice.sv
// tb/tb_soc_addr_decode_slice.sv - vector table and scoreboard bench for the decode slice
module tb_soc_addr_decode_slice;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    soc_addr_decode_slice_if #(.IdWidth(4), .CntWidth(CW)) bus ();

    soc_addr_decode_slice #(.IdWidth(4), .DRAMLength(64'h4000_0000), .CntWidth(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        bit          is_err;
        bit          write;
        logic [63:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [3:0]  sel;
        bit          last;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        bit          write;
        logic [3:0]  id;
        logic [7:0]  len;
        bit          hit;
        logic [3:0]  sel;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    bit   sb_en = 1'b1;
    bit   last_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        last_acc = bus.req_valid_i && bus.req_ready_o;
        if (sb_en && ((bus.mst_valid_o && bus.mst_ready_i) || (bus.err_valid_o && bus.err_ready_i))) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_beat", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                if (bus.mst_valid_o) begin
                    chk("fwd_kind", 1'b0, e.is_err);
                    chk("fwd_addr", bus.mst_addr_o, e.addr);
                    chk("fwd_write", bus.mst_write_o, e.write);
                    chk("fwd_len", bus.mst_len_o, e.len);
                    chk("fwd_id", bus.mst_id_o, e.id);
                    chk("fwd_sel", bus.mst_sel_o, e.sel);
                end else begin
                    chk("err_kind", 1'b1, e.is_err);
                    chk("err_write", bus.err_write_o, e.write);
                    chk("err_id", bus.err_id_o, e.id);
                    chk("err_last", bus.err_last_o, e.last);
                    chk("err_resp", bus.err_resp_o, 2'b11);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_req(input logic [63:0] a, input bit w, input logic [3:0] id,
                              input logic [7:0] len, input bit hit, input logic [3:0] sel);
        if (hit) begin
            sb.push_back('{is_err: 1'b0, write: w, addr: a, id: id, len: len, sel: sel, last: 1'b0});
        end else begin
            if (exp_cnt < CMAX) exp_cnt++;
            if (w) sb.push_back('{is_err: 1'b1, write: 1'b1, addr: a, id: id, len: len, sel: 4'd0, last: 1'b1});
            else for (int i = 0; i <= int'(len); i++)
                sb.push_back('{is_err: 1'b1, write: 1'b0, addr: a, id: id, len: len, sel: 4'd0, last: (i == int'(len))});
        end
    endtask

    task automatic drive(input logic [63:0] a, input bit w, input logic [3:0] id, input logic [7:0] len);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_write_i = w;
        bus.req_id_i    = id;
        bus.req_len_i   = len;
    endtask

    task automatic wait_accept();
        bit got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            cycle();
            got = last_acc;
        end
        chk("accept_timeout", got, 1'b1);
    endtask

    task automatic drain();
        for (int n = 0; n < 600 && sb.size() > 0; n++) cycle();
        chk("drain", sb.size(), 0);
    endtask

    task automatic send(input logic [63:0] a, input bit w, input logic [3:0] id,
                        input logic [7:0] len, input bit hit, input logic [3:0] sel);
        expect_req(a, w, id, len, hit, sel);
        drive(a, w, id, len);
        wait_accept();
        bus.req_valid_i = 1'b0;
        chk("latency", bus.mst_valid_o | bus.err_valid_o, 1'b1);
        drain();
    endtask

    task automatic add_vec(input logic [63:0] a, input bit w, input logic [3:0] id,
                           input logic [7:0] len, input bit hit, input logic [3:0] sel);
        vecs.push_back('{addr: a, write: w, id: id, len: len, hit: hit, sel: sel});
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_write_i = 1'b0;
        bus.req_len_i   = '0;
        bus.req_id_i    = '0;
        bus.mst_ready_i = 1'b1;
        bus.err_ready_i = 1'b1;

        add_vec(64'h8000_1000, 0, 4'd3, 8'd0, 1, 4'd0);
        add_vec(64'h0C00_0000, 0, 4'd1, 8'd1, 1, 4'd7);
        add_vec(64'h4000_0FFF, 1, 4'd2, 8'd0, 1, 4'd2);
        add_vec(64'h4001_0FFF, 0, 4'd4, 8'd3, 1, 4'd1);
        add_vec(64'h0000_1000, 0, 4'd7, 8'd1, 0, 4'd0);
        add_vec(64'h4000_1000, 1, 4'd8, 8'd0, 0, 4'd0);
        add_vec(64'h0000_0000, 0, 4'd9, 8'd0, 1, 4'd10);
        add_vec(64'h0000_0FFF, 1, 4'd9, 8'd0, 1, 4'd10);
        add_vec(64'h0001_FFFF, 0, 4'd1, 8'd0, 1, 4'd9);
        add_vec(64'h020B_FFFF, 0, 4'd2, 8'd0, 1, 4'd8);
        add_vec(64'h020C_0000, 0, 4'd3, 8'd0, 0, 4'd0);
        add_vec(64'h0FFF_FFFE, 1, 4'd4, 8'd0, 1, 4'd7);
        add_vec(64'h0FFF_FFFF, 0, 4'd5, 8'd2, 0, 4'd0);
        add_vec(64'h1000_0000, 0, 4'd6, 8'd0, 1, 4'd6);
        add_vec(64'h1800_0FFF, 1, 4'd7, 8'd0, 1, 4'd5);
        add_vec(64'h207F_FFFF, 0, 4'd8, 8'd0, 1, 4'd4);
        add_vec(64'h2080_0000, 1, 4'd9, 8'd0, 0, 4'd0);
        add_vec(64'h3000_FFFF, 0, 4'd10, 8'd0, 1, 4'd3);
        add_vec(64'hBFFF_FFFF, 0, 4'd11, 8'd0, 1, 4'd0);
        add_vec(64'hC000_0000, 0, 4'd12, 8'd255, 0, 4'd0);
        add_vec(64'h7FFF_FFFF, 0, 4'd13, 8'd0, 0, 4'd0);
        add_vec(64'hFFFF_FFFF_FFFF_FFFF, 1, 4'd14, 8'd0, 0, 4'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mst_valid", bus.mst_valid_o, 1'b0);
        chk("rst_err_valid", bus.err_valid_o, 1'b0);
        chk("rst_cnt", bus.dec_err_cnt_o, 0);
        chk("rst_mst_addr", bus.mst_addr_o, 64'h0);
        chk("rst_mst_id", bus.mst_id_o, 4'd0);
        rst_n = 1'b1;
        cycle();
        chk("idle_ready", bus.req_ready_o, 1'b1);

        foreach (vecs[i]) begin
            send(vecs[i].addr, vecs[i].write, vecs[i].id, vecs[i].len, vecs[i].hit, vecs[i].sel);
            chk("table_cnt", bus.dec_err_cnt_o, exp_cnt);
        end

        send(64'h5000_0000, 1, 4'd5, 8'd0, 0, 4'd0);
        chk("write_err_cnt", bus.dec_err_cnt_o, exp_cnt);

        expect_req(64'h7000_0000, 0, 4'd6, 8'd3, 0, 4'd0);
        drive(64'h7000_0000, 0, 4'd6, 8'd3);
        wait_accept();
        bus.req_valid_i = 1'b0;
        for (int n = 0; n < 40 && sb.size() > 0; n++) begin
            chk("burst_no_accept", bus.req_ready_o, 1'b0);
            bus.err_ready_i = ~bus.err_ready_i;
            cycle();
        end
        chk("burst_done", sb.size(), 0);
        bus.err_ready_i = 1'b1;
        repeat (2) begin
            cycle();
            chk("burst_no_extra", bus.err_valid_o, 1'b0);
        end

        bus.mst_ready_i = 1'b0;
        expect_req(64'h1000_0000, 0, 4'd1, 8'd2, 1, 4'd6);
        drive(64'h1000_0000, 0, 4'd1, 8'd2);
        wait_accept();
        expect_req(64'h1800_0000, 1, 4'd2, 8'd0, 1, 4'd5);
        drive(64'h1800_0000, 1, 4'd2, 8'd0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_valid", bus.mst_valid_o, 1'b1);
            chk("stall_addr", bus.mst_addr_o, 64'h1000_0000);
            chk("stall_id", bus.mst_id_o, 4'd1);
            chk("stall_ready", bus.req_ready_o, 1'b0);
        end
        bus.mst_ready_i = 1'b1;
        cycle();
        chk("b2b_accept", last_acc, 1'b1);
        bus.req_valid_i = 1'b0;
        chk("b2b_valid", bus.mst_valid_o, 1'b1);
        chk("b2b_addr", bus.mst_addr_o, 64'h1800_0000);
        drain();

        for (int i = 0; i < 20; i++) send(64'h6000_0000 + 64'(i * 4), 0, 4'(i), 8'd0, 0, 4'd0);
        chk("cnt_saturated", bus.dec_err_cnt_o, CMAX);

        sb_en = 1'b0;
        drive(64'h7000_0000, 0, 4'd9, 8'd7);
        wait_accept();
        bus.req_valid_i = 1'b0;
        cycle();
        chk("mid_burst_valid", bus.err_valid_o, 1'b1);
        chk("mid_burst_last", bus.err_last_o, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_err_valid", bus.err_valid_o, 1'b0);
        chk("midrst_mst_valid", bus.mst_valid_o, 1'b0);
        chk("midrst_cnt", bus.dec_err_cnt_o, 0);
        chk("midrst_err_id", bus.err_id_o, 4'd0);
        sb.delete();
        exp_cnt = 0;
        sb_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        chk("post_rst_ready", bus.req_ready_o, 1'b1);
        chk("post_rst_err_valid", bus.err_valid_o, 1'b0);
        send(64'h8000_0000, 1, 4'd15, 8'd4, 1, 4'd0);
        chk("post_rst_cnt", bus.dec_err_cnt_o, exp_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
